tsensor_rd: RTL
===============

TSENSOR_RD -- requirements
Module: tsensor_rd

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SCL_HZ, default 100_000, I2C SCL frequency in Hz.
REQ-003 Parameter DEV_ADDR, default 7'h4B, 7-bit I2C address of the temperature sensor.
REQ-004 Parameter SAMPLE_CYC, default 25_000_000, clock cycles from one read start to the next.
REQ-005 clk  in  1  system clock; the block SHALL use one clock and all flops SHALL be rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 scl_oe  out  1  1 = drive SCL low, 0 = release (open-drain).
REQ-008 sda_oe  out  1  1 = drive SDA low, 0 = release (open-drain).
REQ-009 sda_i  in  1  sampled SDA line, already synchronised externally.
REQ-010 tc  out  13  latest 13-bit two's-complement temperature code, 0.0625 C/LSB.
REQ-011 tc_valid  out  1  one-cycle pulse when tc is updated.
REQ-012 nack_err  out  1  sticky flag, set on any slave NACK; cleared by the next fully successful read.

Function
REQ-013 The block SHALL derive a quarter-bit tick every CLK_HZ/(4*SCL_HZ) cycles (integer division) and advance bus phases only on that tick.
REQ-014 Each transaction SHALL be: START, {DEV_ADDR,0}, slave ACK, 8'h00, slave ACK, repeated START, {DEV_ADDR,1}, slave ACK, MSB read, master ACK, LSB read, master NACK, STOP.
REQ-015 FSM states SHALL be IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_ACK, STOP, WAIT; IDLE -> START on sample-timer expiry; WAIT -> IDLE after one SCL period of bus-free time.
REQ-016 SDA SHALL change only while SCL is low; START and STOP are the only SDA transitions while SCL is high.
REQ-017 Bytes SHALL be sent and received MSB first; received bits SHALL be sampled at the SCL-high midpoint (second quarter tick).
REQ-018 On success, tc SHALL be loaded with {MSB[7:0], LSB[7:3]} and tc_valid SHALL pulse in the cycle the STOP condition completes.
REQ-019 On slave NACK in any RX_ACK state: set nack_err, go directly to STOP, leave tc unchanged, no tc_valid.
REQ-020 The sample timer SHALL free-run and restart at every IDLE -> START; a timer expiry during a transaction SHALL be ignored (no queuing).
REQ-021 SCL clock stretching is not supported; SCL SHALL be driven open-loop.
REQ-022 The first read SHALL start SAMPLE_CYC cycles after reset release.

Reset
REQ-023 While rst_n = 0: state = IDLE, scl_oe = 0, sda_oe = 0, tc = 13'd0, tc_valid = 0, nack_err = 0, all counters 0.
REQ-024 Reset assertion mid-transaction SHALL release both lines immediately (asynchronously); no STOP is issued.

Structure
REQ-025 Package tsensor_pkg SHALL hold the FSM state enum, the register pointer constant TEMP_REG = 8'h00 and the read/write bit constants.
REQ-026 One sub-module, i2c_qtick, SHALL generate the quarter-bit tick from CLK_HZ/SCL_HZ; all other logic stays in tsensor_rd.
REQ-027 tc SHALL connect directly to the tc input of the temperature display pipeline without width or format adaptation.

Verification
REQ-028 ACKing slave model returns 8'h0C, 8'h80 -> tc = 13'h0190 (+25.0 C), one tc_valid pulse, nack_err = 0.
REQ-029 Slave returns 8'hF3, 8'h80 -> tc = 13'h1E70 (-25.0 C), tc_valid pulses.
REQ-030 Slave NACKs the address byte -> nack_err = 1, STOP observed, tc keeps its previous value, no tc_valid; the next ACKed read clears nack_err.
REQ-031 Bus protocol checker across 3 back-to-back samples: no SDA change while SCL high except START/STOP, SCL period = 4 x quarter tick, 2 START conditions and 1 STOP per transaction.
REQ-032 rst_n pulled low during the MSB read -> scl_oe = sda_oe = 0 in the same cycle, tc = 0; the first new START comes SAMPLE_CYC cycles after release.
REQ-033 CLK_HZ = 1_000, SCL_HZ = 100 (quarter tick = 2 cycles) -> measured SCL period = 8 cycles.

Source files
------------

// File: rtl/tsensor_pkg.sv
// rtl/tsensor_pkg.sv - shared types and constants for the I2C temperature sensor reader
package tsensor_pkg;

    // Transaction sequencer states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_TX_BYTE,
        ST_RX_ACK,
        ST_RSTART,
        ST_RX_BYTE,
        ST_TX_ACK,
        ST_STOP,
        ST_WAIT
    } state_e;

    // Register pointer of the temperature register inside the sensor
    localparam logic [7:0] TEMP_REG = 8'h00;

    // I2C direction bit appended to the 7-bit address
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // 13-bit temperature code: MSB byte followed by the upper five LSB bits
    function automatic logic [12:0] tc_pack(input logic [7:0] msb, input logic [7:0] lsb);
        return {msb, lsb[7:3]};
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - quarter-bit tick generator for the I2C bit engine
module i2c_qtick #(
    parameter int CLK_HZ = 100_000_000,
    parameter int SCL_HZ = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int QDIV_RAW = CLK_HZ / (4 * SCL_HZ);
    localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int CW       = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt_q;

    // Divider restarts on clr_i so the first quarter of a transaction is full length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/tsensor_rd.sv
// rtl/tsensor_rd.sv - periodic I2C temperature sensor reader producing a 13-bit code
module tsensor_rd
    import tsensor_pkg::*;
#(
    parameter int         CLK_HZ     = 100_000_000,
    parameter int         SCL_HZ     = 100_000,
    parameter logic [6:0] DEV_ADDR   = 7'h4B,
    parameter int         SAMPLE_CYC = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic [12:0] tc,
    output logic        tc_valid,
    output logic        nack_err
);

    localparam int SCW = $clog2(SAMPLE_CYC + 1);
    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CYC - 1);

    state_e         state_q, state_d;
    logic [1:0]     qph_q, qph_d;       // quarter within the current bit slot
    logic [2:0]     bit_q, bit_d;       // bits remaining in the current byte
    logic [1:0]     tx_idx_q, tx_idx_d; // 0: addr+W, 1: register pointer, 2: addr+R
    logic           rx_idx_q, rx_idx_d; // 0: MSB, 1: LSB
    logic [7:0]     sh_q, sh_d;
    logic [7:0]     msb_q, msb_d;
    logic           ack_q, ack_d;
    logic           fail_q, fail_d;
    logic [12:0]    tc_q, tc_d;
    logic           tc_valid_q, tc_valid_d;
    logic           nack_err_q, nack_err_d;
    logic           scl_oe_q, scl_oe_d;
    logic           sda_oe_q, sda_oe_d;
    logic [SCW-1:0] smp_q, smp_d;
    logic           expire;
    logic           qclr;
    logic           tick;

    i2c_qtick #(
        .CLK_HZ(CLK_HZ),
        .SCL_HZ(SCL_HZ)
    ) u_qtick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (qclr),
        .tick_o (tick)
    );

    function automatic logic [7:0] tx_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return {DEV_ADDR, RW_WRITE};
            2'd1:    return TEMP_REG;
            default: return {DEV_ADDR, RW_READ};
        endcase
    endfunction

    // Sequencer next state, datapath updates and registered line drive decode
    always_comb begin
        state_d    = state_q;
        qph_d      = qph_q;
        bit_d      = bit_q;
        tx_idx_d   = tx_idx_q;
        rx_idx_d   = rx_idx_q;
        sh_d       = sh_q;
        msb_d      = msb_q;
        ack_d      = ack_q;
        fail_d     = fail_q;
        tc_d       = tc_q;
        tc_valid_d = 1'b0;
        nack_err_d = nack_err_q;
        qclr       = 1'b0;
        expire     = (smp_q == SAMPLE_LAST);
        smp_d      = expire ? '0 : smp_q + 1'b1;

        if (state_q == ST_IDLE) begin
            if (expire) begin
                state_d  = ST_START;
                qph_d    = 2'd0;
                qclr     = 1'b1;
                fail_d   = 1'b0;
                tx_idx_d = 2'd0;
                rx_idx_d = 1'b0;
                smp_d    = '0;
            end
        end else if (tick) begin
            qph_d = qph_q + 2'd1;
            case (state_q)
                ST_START: begin
                    if (qph_q == 2'd1) begin
                        state_d = ST_TX_BYTE;
                        qph_d   = 2'd0;
                        bit_d   = 3'd7;
                        sh_d    = tx_byte(2'd0);
                    end
                end
                ST_TX_BYTE: begin
                    if (qph_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_d = ST_RX_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                            sh_d  = {sh_q[6:0], 1'b0};
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (qph_q == 2'd1) begin
                        ack_d = !sda_i;
                    end else if (qph_q == 2'd3) begin
                        if (!ack_q) begin
                            state_d    = ST_STOP;
                            fail_d     = 1'b1;
                            nack_err_d = 1'b1;
                        end else if (tx_idx_q == 2'd0) begin
                            state_d  = ST_TX_BYTE;
                            tx_idx_d = 2'd1;
                            bit_d    = 3'd7;
                            sh_d     = tx_byte(2'd1);
                        end else if (tx_idx_q == 2'd1) begin
                            state_d  = ST_RSTART;
                            tx_idx_d = 2'd2;
                        end else begin
                            state_d = ST_RX_BYTE;
                            bit_d   = 3'd7;
                        end
                    end
                end
                ST_RSTART: begin
                    if (qph_q == 2'd3) begin
                        state_d = ST_TX_BYTE;
                        bit_d   = 3'd7;
                        sh_d    = tx_byte(tx_idx_q);
                    end
                end
                ST_RX_BYTE: begin
                    if (qph_q == 2'd1) begin
                        sh_d = {sh_q[6:0], sda_i};
                    end else if (qph_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            state_d = ST_TX_ACK;
                            if (!rx_idx_q) begin
                                msb_d = sh_q;
                            end
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (qph_q == 2'd3) begin
                        if (!rx_idx_q) begin
                            state_d  = ST_RX_BYTE;
                            rx_idx_d = 1'b1;
                            bit_d    = 3'd7;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // SDA release while SCL is high completes the STOP
                    if (qph_q == 2'd1) begin
                        state_d = ST_WAIT;
                        qph_d   = 2'd0;
                        if (!fail_q) begin
                            tc_d       = tc_pack(msb_q, sh_q);
                            tc_valid_d = 1'b1;
                            nack_err_d = 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (qph_q == 2'd3) begin
                        state_d = ST_IDLE;
                        qph_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Line drive follows the upcoming state so it is registered without extra lag.
        // Bit slots: SCL low in quarters 0 and 3, high in 1 and 2; SDA moves only at quarter 0.
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_d)
            ST_START: begin
                scl_oe_d = (qph_d == 2'd1);
                sda_oe_d = 1'b1;
            end
            ST_TX_BYTE: begin
                scl_oe_d = (qph_d == 2'd0) || (qph_d == 2'd3);
                sda_oe_d = !sh_d[7];
            end
            ST_RX_ACK, ST_RX_BYTE: begin
                scl_oe_d = (qph_d == 2'd0) || (qph_d == 2'd3);
            end
            ST_RSTART: begin
                scl_oe_d = (qph_d == 2'd0) || (qph_d == 2'd3);
                sda_oe_d = (qph_d >= 2'd2);
            end
            ST_TX_ACK: begin
                scl_oe_d = (qph_d == 2'd0) || (qph_d == 2'd3);
                sda_oe_d = !rx_idx_d;
            end
            ST_STOP: begin
                scl_oe_d = (qph_d == 2'd0);
                sda_oe_d = 1'b1;
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases both bus lines at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            qph_q      <= '0;
            bit_q      <= '0;
            tx_idx_q   <= '0;
            rx_idx_q   <= 1'b0;
            sh_q       <= '0;
            msb_q      <= '0;
            ack_q      <= 1'b0;
            fail_q     <= 1'b0;
            tc_q       <= '0;
            tc_valid_q <= 1'b0;
            nack_err_q <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            smp_q      <= '0;
        end else begin
            state_q    <= state_d;
            qph_q      <= qph_d;
            bit_q      <= bit_d;
            tx_idx_q   <= tx_idx_d;
            rx_idx_q   <= rx_idx_d;
            sh_q       <= sh_d;
            msb_q      <= msb_d;
            ack_q      <= ack_d;
            fail_q     <= fail_d;
            tc_q       <= tc_d;
            tc_valid_q <= tc_valid_d;
            nack_err_q <= nack_err_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            smp_q      <= smp_d;
        end
    end

    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;
    assign tc       = tc_q;
    assign tc_valid = tc_valid_q;
    assign nack_err = nack_err_q;

endmodule
